// File: rtl/compute_module_feeder_pkg.sv
// ---------------------------------------------------------------------------
// compute_module_feeder_pkg
// Shared constants for the compute-module feeder slice.
//   GRAPH_WIDTH              width of a bottom graph word
//   DEFAULT_REQUEST_LATENCY  request-to-start delay used when not overridden
//   DEFAULT_EXTRA_DATA_WIDTH default job tag width
//   DEFAULT_FIFO_DEPTH       default bot buffer depth
//   satInc32()               32-bit increment that sticks at all-ones
// ---------------------------------------------------------------------------
package compute_module_feeder_pkg;

    localparam int GRAPH_WIDTH              = 128;
    localparam int DEFAULT_REQUEST_LATENCY  = 3;
    localparam int DEFAULT_EXTRA_DATA_WIDTH = 14;
    localparam int DEFAULT_FIFO_DEPTH       = 8;

    function automatic logic [31:0] satInc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/compute_module_feeder_if.sv
// ---------------------------------------------------------------------------
// compute_module_feeder_if
// Bundles the upstream bot handshake and the compute-module side of the
// feeder.
//   master : the environment (job distributor + compute module) - drives
//            botValid/botData/botExtra/request, observes the rest
//   slave  : the feeder itself - drives botReady/botOut/start/extraDataOut/
//            occupancy/starvedCount
// ---------------------------------------------------------------------------
interface compute_module_feeder_if #(
    parameter int EXTRA_DATA_WIDTH = 14,
    parameter int FIFO_DEPTH       = 8
);
    import compute_module_feeder_pkg::*;

    localparam int OCC_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                        botValid;
    logic [GRAPH_WIDTH-1:0]      botData;
    logic [EXTRA_DATA_WIDTH-1:0] botExtra;
    logic                        botReady;
    logic                        request;
    logic [GRAPH_WIDTH-1:0]      botOut;
    logic                        start;
    logic [EXTRA_DATA_WIDTH-1:0] extraDataOut;
    logic [OCC_WIDTH-1:0]        occupancy;
    logic [31:0]                 starvedCount;

    modport master (
        output botValid, botData, botExtra, request,
        input  botReady, botOut, start, extraDataOut, occupancy, starvedCount
    );

    modport slave (
        input  botValid, botData, botExtra, request,
        output botReady, botOut, start, extraDataOut, occupancy, starvedCount
    );

endinterface

// File: rtl/compute_module_feeder_fifo.sv
// ---------------------------------------------------------------------------
// compute_module_feeder_fifo
// Small synchronous FIFO with registered count and asynchronous reset.
//   clk, rst   clock, async active-high reset (pointers/count only)
//   pushValid  write request; accepted only when not full
//   pushData   word to store
//   popEn      read request; honoured only when not empty
//   headData   current head word (valid whenever empty=0)
//   count      registered number of stored entries
//   full/empty derived from count
// ---------------------------------------------------------------------------
module compute_module_feeder_fifo #(
    parameter int WIDTH = 142,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pushValid,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     popEn,
    output logic [WIDTH-1:0]         headData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    logic [WIDTH-1:0]     memory [DEPTH];
    logic [PTR_WIDTH-1:0] wrPtrReg;
    logic [PTR_WIDTH-1:0] rdPtrReg;
    logic [CNT_WIDTH-1:0] countReg;
    logic                 doPush;
    logic                 doPop;

    assign full   = (countReg == CNT_WIDTH'(DEPTH));
    assign empty  = (countReg == '0);
    assign doPush = pushValid & ~full;
    assign doPop  = popEn & ~empty;

    // Head is read combinationally so a pop can load the latency pipe on the
    // same edge that advances the read pointer.
    assign headData = memory[rdPtrReg];
    assign count    = countReg;

    // Storage carries no reset; only the bookkeeping does.
    always_ff @(posedge clk) begin
        if (doPush) begin
            memory[wrPtrReg] <= pushData;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_WIDTH'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PTR_WIDTH'(1);
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + CNT_WIDTH'(1);
                2'b01:   countReg <= countReg - CNT_WIDTH'(1);
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/compute_module_feeder.sv
// ---------------------------------------------------------------------------
// compute_module_feeder
// Feeds one compute module: buffers upstream bots and answers each request
// with a start strobe plus bottom graph and tag exactly REQUEST_LATENCY
// cycles later. Requests arriving with an empty buffer are counted.
//   clk, rst  clock, async active-high reset
//   bus       compute_module_feeder_if.slave:
//               botValid/botData/botExtra/botReady  upstream push handshake
//               request                             requestGraph pulse
//               start/botOut/extraDataOut           delayed response
//               occupancy                           buffer entry count
//               starvedCount                        saturating starve count
// ---------------------------------------------------------------------------
module compute_module_feeder
    import compute_module_feeder_pkg::*;
#(
    parameter int EXTRA_DATA_WIDTH = DEFAULT_EXTRA_DATA_WIDTH,
    parameter int REQUEST_LATENCY  = DEFAULT_REQUEST_LATENCY,
    parameter int FIFO_DEPTH       = DEFAULT_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    compute_module_feeder_if.slave  bus
);
    localparam int ENTRY_WIDTH = GRAPH_WIDTH + EXTRA_DATA_WIDTH;

    logic                          fifoFull;
    logic                          fifoEmpty;
    logic [ENTRY_WIDTH-1:0]        headEntry;
    logic [$clog2(FIFO_DEPTH):0]   fifoCount;
    logic                          popping;
    logic                          starving;
    logic [31:0]                   starvedCountReg;
    logic [31:0]                   starvedCountNext;

    // Chain taps: index 0 is the pipe input, index REQUEST_LATENCY the output.
    logic [REQUEST_LATENCY:0]                  startChain;
    logic [REQUEST_LATENCY:0][ENTRY_WIDTH-1:0] dataChain;

    compute_module_feeder_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) feederFifo (
        .clk       (clk),
        .rst       (rst),
        .pushValid (bus.botValid),
        .pushData  ({bus.botData, bus.botExtra}),
        .popEn     (bus.request),
        .headData  (headEntry),
        .count     (fifoCount),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    // Ready comes from the registered count only, so a pop in the same
    // cycle cannot open the door while full. Held low during reset.
    assign bus.botReady = ~rst & ~fifoFull;
    assign bus.occupancy = fifoCount;

    // A push landing on an empty FIFO in the same cycle is not forwarded:
    // the request starves and the entry stays buffered.
    assign popping  = bus.request & ~fifoEmpty;
    assign starving = bus.request & fifoEmpty;

    // Gating the data at the pipe input keeps the outputs zero whenever
    // start is low, with no extra mux at the output.
    assign startChain[0] = popping;
    assign dataChain[0]  = popping ? headEntry : '0;

    generate
        for (genvar gi = 0; gi < REQUEST_LATENCY; gi++) begin : gLatencyStage
            logic                   startReg;
            logic [ENTRY_WIDTH-1:0] dataReg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    startReg <= 1'b0;
                    dataReg  <= '0;
                end else begin
                    startReg <= startChain[gi];
                    dataReg  <= dataChain[gi];
                end
            end

            assign startChain[gi+1] = startReg;
            assign dataChain[gi+1]  = dataReg;
        end
    endgenerate

    assign bus.start        = startChain[REQUEST_LATENCY];
    assign bus.botOut       = dataChain[REQUEST_LATENCY][ENTRY_WIDTH-1:EXTRA_DATA_WIDTH];
    assign bus.extraDataOut = dataChain[REQUEST_LATENCY][EXTRA_DATA_WIDTH-1:0];

    assign starvedCountNext = starving ? satInc32(starvedCountReg) : starvedCountReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starvedCountReg <= '0;
        end else begin
            starvedCountReg <= starvedCountNext;
        end
    end

    assign bus.starvedCount = starvedCountReg;

endmodule

// File: tb/tb_compute_module_feeder.sv
// ---------------------------------------------------------------------------
// tb_compute_module_feeder
// Directed bench for compute_module_feeder (REQUEST_LATENCY=3, FIFO_DEPTH=8,
// EXTRA_DATA_WIDTH=14). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, so "step i" below means cycle
// t+i relative to the cycle t whose closing edge sampled the request.
// ---------------------------------------------------------------------------
module tb_compute_module_feeder;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] expStarved;

    compute_module_feeder_if #(
        .EXTRA_DATA_WIDTH (14),
        .FIFO_DEPTH       (8)
    ) feederBus ();

    compute_module_feeder #(
        .EXTRA_DATA_WIDTH (14),
        .REQUEST_LATENCY  (3),
        .FIFO_DEPTH       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (feederBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        feederBus.botValid = 1'b0;
        feederBus.botData  = '0;
        feederBus.botExtra = '0;
        feederBus.request  = 1'b0;
        step();
        step();
        checks++; if (feederBus.start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", feederBus.start); end
        checks++; if (feederBus.botOut !== 128'h0) begin errors++; $display("FAIL reset_botOut got=%h exp=0", feederBus.botOut); end
        checks++; if (feederBus.extraDataOut !== 14'h0) begin errors++; $display("FAIL reset_extra got=%h exp=0", feederBus.extraDataOut); end
        checks++; if (feederBus.occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", feederBus.occupancy); end
        checks++; if (feederBus.starvedCount !== 32'd0) begin errors++; $display("FAIL reset_starved got=%0d exp=0", feederBus.starvedCount); end
        checks++; if (feederBus.botReady !== 1'b0) begin errors++; $display("FAIL reset_botReady got=%b exp=0", feederBus.botReady); end
        rst = 1'b0;
        #1;
        checks++; if (feederBus.botReady !== 1'b1) begin errors++; $display("FAIL release_botReady got=%b exp=1", feederBus.botReady); end
        repeat (7) step();
        // Starved request with an empty FIFO.
        feederBus.request = 1'b1;
        step();
        feederBus.request = 1'b0;
        expStarved = 32'd1;
        checks++; if (feederBus.starvedCount !== expStarved) begin errors++; $display("FAIL starve_count got=%0d exp=%0d", feederBus.starvedCount, expStarved); end
        for (int i = 2; i <= 6; i++) begin
            step();
            checks++; if (feederBus.start !== 1'b0 || feederBus.botOut !== 128'h0 || feederBus.extraDataOut !== 14'h0) begin
                errors++; $display("FAIL starve_no_start step=%0d got start=%b bot=%h extra=%h exp 0/0/0", i, feederBus.start, feederBus.botOut, feederBus.extraDataOut);
            end
        end
        $display("reset + starved request done, starvedCount=%0d", feederBus.starvedCount);
    endtask

    task automatic test_two_entries();
        feederBus.botValid = 1'b1;
        feederBus.botData  = 128'h1;
        feederBus.botExtra = 14'd5;
        step();
        feederBus.botData  = 128'h2;
        feederBus.botExtra = 14'd6;
        step();
        feederBus.botValid = 1'b0;
        checks++; if (feederBus.occupancy !== 4'd2) begin errors++; $display("FAIL two_occupancy got=%0d exp=2", feederBus.occupancy); end
        feederBus.request = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 2) feederBus.request = 1'b0;
            if (i == 2) begin
                checks++; if (feederBus.occupancy !== 4'd0) begin errors++; $display("FAIL two_drained got=%0d exp=0", feederBus.occupancy); end
            end
            if (i == 3) begin
                checks++; if (feederBus.start !== 1'b1 || feederBus.botOut !== 128'h1 || feederBus.extraDataOut !== 14'd5) begin
                    errors++; $display("FAIL two_first got start=%b bot=%h extra=%0d exp 1/1/5", feederBus.start, feederBus.botOut, feederBus.extraDataOut);
                end
            end else if (i == 4) begin
                checks++; if (feederBus.start !== 1'b1 || feederBus.botOut !== 128'h2 || feederBus.extraDataOut !== 14'd6) begin
                    errors++; $display("FAIL two_second got start=%b bot=%h extra=%0d exp 1/2/6", feederBus.start, feederBus.botOut, feederBus.extraDataOut);
                end
            end else begin
                checks++; if (feederBus.start !== 1'b0 || feederBus.botOut !== 128'h0) begin
                    errors++; $display("FAIL two_idle step=%0d got start=%b bot=%h exp 0/0", i, feederBus.start, feederBus.botOut);
                end
            end
            if (feederBus.start === 1'b1) $display("start step=%0d bot=%h extra=%0d", i, feederBus.botOut, feederBus.extraDataOut);
        end
    endtask

    task automatic test_fill();
        int got;
        feederBus.botValid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            feederBus.botData  = 128'(16 + k);
            feederBus.botExtra = 14'(k);
            checks++; if (feederBus.botReady !== 1'b1) begin errors++; $display("FAIL fill_ready k=%0d got=%b exp=1", k, feederBus.botReady); end
            step();
            $display("push k=%0d occupancy=%0d", k, feederBus.occupancy);
        end
        checks++; if (feederBus.occupancy !== 4'd8) begin errors++; $display("FAIL fill_full_occ got=%0d exp=8", feederBus.occupancy); end
        checks++; if (feederBus.botReady !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", feederBus.botReady); end
        // Ninth offer is held and must not be taken.
        feederBus.botData  = 128'h1FF;
        feederBus.botExtra = 14'h3FF;
        step();
        step();
        checks++; if (feederBus.occupancy !== 4'd8) begin errors++; $display("FAIL fill_held_occ got=%0d exp=8", feederBus.occupancy); end
        feederBus.botValid = 1'b0;
        feederBus.request  = 1'b1;
        got = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 1) begin
                checks++; if (feederBus.botReady !== 1'b1 || feederBus.occupancy !== 4'd7) begin
                    errors++; $display("FAIL fill_reopen got ready=%b occ=%0d exp 1/7", feederBus.botReady, feederBus.occupancy);
                end
            end
            if (i == 8) feederBus.request = 1'b0;
            checks++; if (feederBus.start !== (i >= 3 && i <= 10)) begin
                errors++; $display("FAIL fill_start step=%0d got=%b exp=%b", i, feederBus.start, (i >= 3 && i <= 10));
            end
            if (feederBus.start === 1'b1) begin
                checks++; if (feederBus.botOut !== 128'(16 + got) || feederBus.extraDataOut !== 14'(got)) begin
                    errors++; $display("FAIL fill_order idx=%0d got bot=%h extra=%0d exp bot=%h extra=%0d", got, feederBus.botOut, feederBus.extraDataOut, 128'(16 + got), got);
                end
                $display("start idx=%0d bot=%h extra=%0d", got, feederBus.botOut, feederBus.extraDataOut);
                got++;
            end
        end
        checks++; if (got !== 8) begin errors++; $display("FAIL fill_count got=%0d exp=8", got); end
        checks++; if (feederBus.occupancy !== 4'd0) begin errors++; $display("FAIL fill_empty got=%0d exp=0", feederBus.occupancy); end
    endtask

    task automatic test_push_and_starve();
        feederBus.botValid = 1'b1;
        feederBus.botData  = 128'hABC;
        feederBus.botExtra = 14'd9;
        feederBus.request  = 1'b1;
        step();
        feederBus.botValid = 1'b0;
        expStarved = expStarved + 32'd1;
        checks++; if (feederBus.starvedCount !== expStarved) begin errors++; $display("FAIL pns_starved got=%0d exp=%0d", feederBus.starvedCount, expStarved); end
        checks++; if (feederBus.occupancy !== 4'd1) begin errors++; $display("FAIL pns_occ got=%0d exp=1", feederBus.occupancy); end
        for (int i = 2; i <= 5; i++) begin
            step();
            if (i == 2) begin
                feederBus.request = 1'b0;
                checks++; if (feederBus.occupancy !== 4'd0 || feederBus.starvedCount !== expStarved) begin
                    errors++; $display("FAIL pns_second got occ=%0d starved=%0d exp 0/%0d", feederBus.occupancy, feederBus.starvedCount, expStarved);
                end
            end
            if (i == 4) begin
                checks++; if (feederBus.start !== 1'b1 || feederBus.botOut !== 128'hABC || feederBus.extraDataOut !== 14'd9) begin
                    errors++; $display("FAIL pns_served got start=%b bot=%h extra=%0d exp 1/abc/9", feederBus.start, feederBus.botOut, feederBus.extraDataOut);
                end
                $display("start bot=%h extra=%0d", feederBus.botOut, feederBus.extraDataOut);
            end else begin
                checks++; if (feederBus.start !== 1'b0) begin errors++; $display("FAIL pns_idle step=%0d got=%b exp=0", i, feederBus.start); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        feederBus.botValid = 1'b1;
        feederBus.botData  = 128'h55;
        feederBus.botExtra = 14'd3;
        step();
        feederBus.botValid = 1'b0;
        feederBus.request  = 1'b1;
        step();
        feederBus.request = 1'b0;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (feederBus.start !== 1'b0 || feederBus.botOut !== 128'h0 || feederBus.extraDataOut !== 14'h0 ||
                          feederBus.occupancy !== 4'd0 || feederBus.starvedCount !== 32'd0 || feederBus.botReady !== 1'b0) begin
                errors++; $display("FAIL midreset_outputs i=%0d got start=%b bot=%h extra=%h occ=%0d starved=%0d ready=%b exp all 0",
                                   i, feederBus.start, feederBus.botOut, feederBus.extraDataOut, feederBus.occupancy, feederBus.starvedCount, feederBus.botReady);
            end
            step();
        end
        rst = 1'b0;
        expStarved = 32'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (feederBus.start !== 1'b0 || feederBus.occupancy !== 4'd0) begin
                errors++; $display("FAIL midreset_after i=%0d got start=%b occ=%0d exp 0/0", i, feederBus.start, feederBus.occupancy);
            end
        end
        $display("mid-flight reset done");
    endtask

    task automatic test_saturate();
        force dut.starvedCountNext = 32'hFFFF_FFFE;
        step();
        release dut.starvedCountNext;
        checks++; if (feederBus.starvedCount !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffffffe", feederBus.starvedCount); end
        feederBus.request = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (feederBus.starvedCount !== 32'hFFFF_FFFF) begin
                errors++; $display("FAIL sat_hold i=%0d got=%h exp=ffffffff", i, feederBus.starvedCount);
            end
            $display("starved request i=%0d count=%h", i, feederBus.starvedCount);
        end
        feederBus.request = 1'b0;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        expStarved = 32'd0;
        test_reset();
        test_two_entries();
        test_fill();
        test_push_and_starve();
        test_reset_midflight();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/compute_module_feeder.md
Name: compute_module_feeder

Overview:
- Drives the input side of one compute module: answers each `requestGraph` pulse with a bottom graph, a start strobe and extra data.
- The answer arrives exactly REQUEST_LATENCY cycles after the request.
- Buffers upstream bots in a small FIFO and counts requests it could not serve.
- Sits between the job distributor and a single compute module instance.

Parameters:
- EXTRA_DATA_WIDTH, 14: width of the per-job tag carried alongside each bot.
- REQUEST_LATENCY, 3: cycles from request sample to start/bot/extra presentation. Must be ≥1.
- FIFO_DEPTH, 8: entries in the bot buffer. Power of two, ≥2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- botValid  in  1  upstream entry valid.
- botData  in  128  upstream bottom graph.
- botExtra  in  EXTRA_DATA_WIDTH  upstream job tag.
- botReady  out  1  FIFO can accept; a push happens when botValid & botReady.
- request  in  1  requestGraph from the compute module.
- botOut  out  128  bottom graph to the compute module.
- start  out  1  one-cycle strobe: botOut/extraDataOut valid.
- extraDataOut  out  EXTRA_DATA_WIDTH  tag to the compute module.
- occupancy  out  $clog2(FIFO_DEPTH)+1  current FIFO entry count.
- starvedCount  out  32  requests that arrived while the FIFO was empty, saturating.

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers and occupancy = 0.
  - All latency-pipe stages cleared; start=0, botOut=0, extraDataOut=0.
  - starvedCount = 0.
  - botReady = 0 while rst is high, 1 from the first cycle after release.
  - In-flight responses are discarded; no start emerges from a request sampled before reset.
- Push: occurs on cycle t when botValid & botReady.
  - botReady = (occupancy != FIFO_DEPTH), combinational from the registered count.
  - A same-cycle pop does not raise botReady when full.
- Pop: occurs when request=1 and occupancy != 0 on cycle t.
  - Head entry enters pipe stage 1 with start bit 1.
  - Simultaneous push and pop: occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- Starve: request=1 and occupancy == 0 on cycle t.
  - Pipe stage 1 gets start bit 0.
  - starvedCount increments at t+1, holding at 32'hFFFFFFFF.
  - There is no bypass: a push on the same cycle does not satisfy the request; the entry is stored.
- Latency pipe: REQUEST_LATENCY registered stages.
  - Outputs are registered.
  - A request popped on cycle t gives start=1 on cycle t+REQUEST_LATENCY, with that entry's botData/botExtra.
  - Back-to-back requests give back-to-back starts, in FIFO order.
- Gating: botOut and extraDataOut are 0 whenever start=0.
- request=0 cycles shift zeros into the pipe.
- Data is never dropped or duplicated. Every push is emitted exactly once unless reset intervenes.
- occupancy is registered and reflects pushes/pops from the previous cycle.

Decomposition:
- Shared header (alongside existing defines):
  - 128-bit graph width constant.
  - default REQUEST_LATENCY.
- Natural sub-module: feeder_fifo, a parameterised synchronous FIFO providing count/full/empty with async reset.
- The latency pipe is a generic parameterised delay line. Reuse the codebase's existing shift-register primitive, with a reset-capable variant for the start bit.

Test Plan:
- Reset with empty FIFO, then pulse request at cycle 10 (REQUEST_LATENCY=3):
  - start stays 0 throughout.
  - botOut=0, extraDataOut=0.
  - starvedCount=1 at cycle 11.
- Push A (data 128'h1, tag 5) then B (data 128'h2, tag 6); request on cycles 20 and 21:
  - start=1 on cycles 23 and 24.
  - Cycle 23 carries 128'h1/5; cycle 24 carries 128'h2/6.
  - occupancy returns to 0.
- Push 8 entries with botValid held high:
  - botReady falls once occupancy=8; the 9th offer is held, not accepted.
  - One request restores botReady the next cycle.
  - All 8 entries later emerge in order.
- Simultaneous push and request with occupancy 0:
  - start=0 at +3; starvedCount += 1; occupancy=1.
  - A second request 1 cycle later returns the pushed entry at +3.
- Reset asserted mid-flight, 1 cycle after a served request:
  - start never pulses for that request.
  - All outputs read 0 during reset.
  - FIFO empty after release.
- Preload starvedCount near wrap (force 32'hFFFFFFFE), then 3 starved requests:
  - Count reads 32'hFFFFFFFF and holds.
